// File: rtl/dstack_alu_seq_pkg.sv
// Shared encodings for the data-stack sequencer, its external ALU and the command decoder.
// Holds command codes, FSM states, ALU opcodes, error-flag masks and opcode classification helpers.
package dstack_alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_DROP  = 2'd1,
    OP_BINOP = 2'd2,
    OP_UNOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_MOD  = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd8;
  localparam logic [3:0] ALU_NOT  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;
  localparam logic [3:0] ALU_SHL  = 4'd11;
  localparam logic [3:0] ALU_SHR  = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_ROL  = 4'd14;
  localparam logic [3:0] ALU_ROR  = 4'd15;

  localparam logic [2:0] ERR_UNDER   = 3'b001;
  localparam logic [2:0] ERR_OVER    = 3'b010;
  localparam logic [2:0] ERR_ILLEGAL = 3'b100;

  function automatic logic is_unary_op(input logic [3:0] op);
    return (op == ALU_NOT) || (op == ALU_PASS);
  endfunction

  // DIV and MOD trap on a zero divisor before the ALU ever sees them.
  function automatic logic needs_nonzero_b(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/dstack_alu_seq_mem.sv
// Register-array stack holding the entries below TOS; push writes, pop discards, peek shows the top.
// Contents are never reset, only the fill count.
module dstack_mem
  import dstack_alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] peek
);

  localparam int N  = DEPTH - 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  entries [N];
  logic [4:0]    cnt_r;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] top_idx_s;

  assign wr_idx_s  = cnt_r[AW-1:0];
  assign top_idx_s = AW'(cnt_r - 5'd1);

  // Fill count; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 5'd0;
    end else if (push && !pop) begin
      cnt_r <= cnt_r + 5'd1;
    end else if (pop && !push) begin
      cnt_r <= cnt_r - 5'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      entries[wr_idx_s] <= push_data;
    end
  end

  // Top entry, reading as zero when the array is empty.
  always_comb begin
    peek = {W{1'b0}};
    if (cnt_r != 5'd0) begin
      peek = entries[top_idx_s];
    end else begin
      peek = {W{1'b0}};
    end
  end

endmodule

// File: rtl/dstack_alu_seq.sv
// Data-stack sequencer: PUSH/DROP commit at acceptance, BINOP/UNOP go through an external ALU.
// All command checks happen at acceptance so rejected commands never leave IDLE.
module dstack_alu_seq
  import dstack_alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [3:0]   cmd_aluop,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_res,
  output logic [W-1:0] tos,
  output logic [4:0]   depth,
  output logic         done,
  output logic [2:0]   err,
  input  logic         err_clr
);

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  state_e       state_r;
  logic         ready_r;
  logic         done_r;
  logic         unary_r;
  logic [W-1:0] tos_r;
  logic [W-1:0] alu_a_r;
  logic [W-1:0] alu_b_r;
  logic [3:0]   alu_op_r;
  logic [3:0]   pend_op_r;
  logic [4:0]   depth_r;
  logic [2:0]   err_r;

  cmd_op_e      op_s;
  logic         accept_s;
  logic         commit_s;
  logic [2:0]   rej_s;
  logic [2:0]   err_nxt_s;
  logic         mem_push_s;
  logic         mem_pop_s;
  logic [W-1:0] nos_s;

  assign op_s     = cmd_op_e'(cmd_op);
  assign accept_s = cmd_valid && (state_r == ST_IDLE);
  assign commit_s = accept_s && (rej_s == 3'b000);

  // Rejection reason for the command on the bus; underflow outranks an illegal opcode.
  always_comb begin
    rej_s = 3'b000;
    case (op_s)
      OP_PUSH: begin
        if (depth_r == DEPTH_MAX) rej_s = ERR_OVER;
        else                      rej_s = 3'b000;
      end
      OP_DROP: begin
        if (depth_r == 5'd0) rej_s = ERR_UNDER;
        else                 rej_s = 3'b000;
      end
      OP_BINOP: begin
        if (depth_r < 5'd2)                                          rej_s = ERR_UNDER;
        else if (cmd_aluop == ALU_NONE)                              rej_s = ERR_ILLEGAL;
        else if (needs_nonzero_b(cmd_aluop) && (tos_r == {W{1'b0}})) rej_s = ERR_ILLEGAL;
        else                                                         rej_s = 3'b000;
      end
      OP_UNOP: begin
        if (depth_r == 5'd0)             rej_s = ERR_UNDER;
        else if (!is_unary_op(cmd_aluop)) rej_s = ERR_ILLEGAL;
        else                             rej_s = 3'b000;
      end
      default: rej_s = 3'b000;
    endcase
  end

  // Sticky error flags; a clear in the same cycle as a new error keeps only the new bit.
  always_comb begin
    err_nxt_s = err_clr ? 3'b000 : err_r;
    if (accept_s) begin
      err_nxt_s = err_nxt_s | rej_s;
    end else begin
      err_nxt_s = err_nxt_s;
    end
  end

  // The old TOS spills to memory only when it was a real entry.
  always_comb begin
    mem_push_s = commit_s && (op_s == OP_PUSH) && (depth_r != 5'd0);
    mem_pop_s  = (commit_s && (op_s == OP_DROP) && (depth_r > 5'd1)) ||
                 ((state_r == ST_EXEC) && !unary_r);
  end

  dstack_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push_s),
    .pop       (mem_pop_s),
    .push_data (tos_r),
    .peek      (nos_s)
  );

  // Command sequencer with registered stack and ALU-operand outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      unary_r   <= 1'b0;
      tos_r     <= {W{1'b0}};
      alu_a_r   <= {W{1'b0}};
      alu_b_r   <= {W{1'b0}};
      alu_op_r  <= 4'd0;
      pend_op_r <= 4'd0;
      depth_r   <= 5'd0;
      err_r     <= 3'b000;
    end else begin
      done_r <= 1'b0;
      err_r  <= err_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (rej_s != 3'b000)) begin
            done_r <= 1'b1;
          end else if (commit_s) begin
            case (op_s)
              OP_PUSH: begin
                tos_r   <= cmd_data;
                depth_r <= depth_r + 5'd1;
                done_r  <= 1'b1;
              end
              OP_DROP: begin
                tos_r   <= nos_s;
                depth_r <= depth_r - 5'd1;
                done_r  <= 1'b1;
              end
              OP_BINOP: begin
                pend_op_r <= cmd_aluop;
                unary_r   <= 1'b0;
                ready_r   <= 1'b0;
                state_r   <= ST_FETCH;
              end
              OP_UNOP: begin
                alu_a_r  <= {W{1'b0}};
                alu_b_r  <= tos_r;
                alu_op_r <= cmd_aluop;
                unary_r  <= 1'b1;
                ready_r  <= 1'b0;
                state_r  <= ST_EXEC;
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_FETCH: begin
          alu_a_r  <= nos_s;
          alu_b_r  <= tos_r;
          alu_op_r <= pend_op_r;
          state_r  <= ST_EXEC;
        end
        ST_EXEC: begin
          tos_r <= alu_res;
          if (!unary_r) begin
            depth_r <= depth_r - 5'd1;
          end
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign tos       = tos_r;
  assign depth     = depth_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_dstack_alu_seq.sv
// Self-checking bench for dstack_alu_seq: vector table plus overflow/underflow and reset sequences.
// A small ALU model drives alu_res; expected results queue at acceptance and pop on done.
module tb_dstack_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_aluop;
  logic [15:0] cmd_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_res;
  logic [15:0] tos;
  logic [4:0]  depth;
  logic        done;
  logic [2:0]  err;
  logic        err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  aluop;
    logic [15:0] data;
    logic        clr;
    logic [15:0] e_tos;
    logic [4:0]  e_depth;
    logic [2:0]  e_err;
    logic [3:0]  e_lat;
    logic        chk;
    logic [15:0] e_a;
    logic [15:0] e_b;
  } vec_t;

  typedef struct {
    logic [15:0] tos;
    logic [4:0]  depth;
    logic [2:0]  err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tv[21];

  dstack_alu_seq #(.DEPTH(16), .W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_aluop(cmd_aluop), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .tos(tos), .depth(depth), .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: a = NOS, b = TOS.
  always_comb begin
    alu_res = 16'd0;
    case (alu_op)
      4'd1:    alu_res = alu_a + alu_b;
      4'd2:    alu_res = alu_a - alu_b;
      4'd4:    alu_res = (alu_b != 16'd0) ? alu_a / alu_b : 16'd0;
      4'd5:    alu_res = (alu_b != 16'd0) ? alu_a % alu_b : 16'd0;
      4'd9:    alu_res = ~alu_b;
      4'd10:   alu_res = alu_b;
      default: alu_res = 16'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("tos", 32'(tos), 32'(e.tos));
        check("depth", 32'(depth), 32'(e.depth));
        check("err", 32'(err), 32'(e.err));
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        check("ready_at_done", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic run_cmd(input vec_t v);
    exp_t e;
    int   k;
    @(negedge clk);
    for (k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_aluop = v.aluop;
    cmd_data  = v.data;
    err_clr   = v.clr;
    @(posedge clk);
    #1;
    e.tos = v.e_tos; e.depth = v.e_depth; e.err = v.e_err; e.acc = cyc; e.lat = int'(v.e_lat);
    sb.push_back(e);
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    cmd_data  = 16'($urandom);
    if (v.chk) begin
      repeat (int'(v.e_lat) - 1) @(negedge clk);
      if (v.op == 2'd2) check("exec_alu_a", 32'(alu_a), 32'(v.e_a));
      check("exec_alu_b", 32'(alu_b), 32'(v.e_b));
      check("exec_alu_op", 32'(alu_op), 32'(v.aluop));
      check("exec_not_ready", 32'(cmd_ready), 32'd0);
    end
    for (k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;
    int   k;
    // op aluop data clr | tos depth err lat | chk a b
    tv[0]  = '{2'd0, 4'd0,  16'd7, 1'b0, 16'd7,      5'd1, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[1]  = '{2'd0, 4'd0,  16'd3, 1'b0, 16'd3,      5'd2, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[2]  = '{2'd2, 4'd2,  16'd0, 1'b0, 16'd4,      5'd1, 3'd0, 4'd3, 1'b1, 16'd7, 16'd3};
    tv[3]  = '{2'd1, 4'd0,  16'd0, 1'b0, 16'd0,      5'd0, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[4]  = '{2'd0, 4'd0,  16'd5, 1'b0, 16'd5,      5'd1, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[5]  = '{2'd3, 4'd9,  16'd0, 1'b0, 16'hFFFA,   5'd1, 3'd0, 4'd2, 1'b1, 16'd0, 16'd5};
    tv[6]  = '{2'd3, 4'd1,  16'd0, 1'b0, 16'hFFFA,   5'd1, 3'd4, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[7]  = '{2'd1, 4'd0,  16'd0, 1'b1, 16'd0,      5'd0, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[8]  = '{2'd1, 4'd0,  16'd0, 1'b0, 16'd0,      5'd0, 3'd1, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[9]  = '{2'd0, 4'd0,  16'd9, 1'b1, 16'd9,      5'd1, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[10] = '{2'd0, 4'd0,  16'd0, 1'b0, 16'd0,      5'd2, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[11] = '{2'd2, 4'd4,  16'd0, 1'b0, 16'd0,      5'd2, 3'd4, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[12] = '{2'd2, 4'd1,  16'd0, 1'b0, 16'd9,      5'd1, 3'd4, 4'd3, 1'b0, 16'd0, 16'd0};
    tv[13] = '{2'd2, 4'd1,  16'd0, 1'b1, 16'd9,      5'd1, 3'd1, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[14] = '{2'd0, 4'd0,  16'd2, 1'b0, 16'd2,      5'd2, 3'd1, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[15] = '{2'd2, 4'd0,  16'd0, 1'b0, 16'd2,      5'd2, 3'd5, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[16] = '{2'd2, 4'd5,  16'd0, 1'b0, 16'd1,      5'd1, 3'd5, 4'd3, 1'b1, 16'd9, 16'd2};
    tv[17] = '{2'd3, 4'd10, 16'd0, 1'b1, 16'd1,      5'd1, 3'd0, 4'd2, 1'b1, 16'd0, 16'd1};
    tv[18] = '{2'd3, 4'd0,  16'd0, 1'b0, 16'd1,      5'd1, 3'd4, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[19] = '{2'd1, 4'd0,  16'd0, 1'b0, 16'd0,      5'd0, 3'd4, 4'd1, 1'b0, 16'd0, 16'd0};
    tv[20] = '{2'd3, 4'd9,  16'd0, 1'b1, 16'd0,      5'd0, 3'd1, 4'd1, 1'b0, 16'd0, 16'd0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_aluop = 4'd0;
    cmd_data = 16'd0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_alu", {alu_a, alu_b} ^ 32'(alu_op), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) run_cmd(tv[i]);

    // Fill to capacity, overflow once, then drain and underflow.
    for (int i = 0; i < 16; i++) begin
      v = '{2'd0, 4'd0, 16'(100 + i), (i == 0), 16'(100 + i), 5'(i + 1), 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
      run_cmd(v);
    end
    run_cmd('{2'd0, 4'd0, 16'd999, 1'b0, 16'd115, 5'd16, 3'd2, 4'd1, 1'b0, 16'd0, 16'd0});
    for (int i = 1; i <= 16; i++) begin
      v = '{2'd1, 4'd0, 16'd0, (i == 1), ((16 - i) > 0) ? 16'(115 - i) : 16'd0,
            5'(16 - i), 3'd0, 4'd1, 1'b0, 16'd0, 16'd0};
      run_cmd(v);
    end
    run_cmd('{2'd1, 4'd0, 16'd0, 1'b0, 16'd0, 5'd0, 3'd1, 4'd1, 1'b0, 16'd0, 16'd0});

    // Reset landing in the FETCH cycle of a BINOP.
    run_cmd('{2'd0, 4'd0, 16'd1, 1'b1, 16'd1, 5'd1, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0});
    run_cmd('{2'd0, 4'd0, 16'd2, 1'b0, 16'd2, 5'd2, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_aluop = 4'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("fetch_not_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_depth", 32'(depth), 32'd0);
    check("midrst_tos", 32'(tos), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) k++;
    end
    check("midrst_no_done", 32'(k), 32'd0);
    run_cmd('{2'd0, 4'd0, 16'h1234, 1'b0, 16'h1234, 5'd1, 3'd0, 4'd1, 1'b0, 16'd0, 16'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dstack_alu_seq.md
DSTACK_ALU_SEQ -- requirements
Module: dstack_alu_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the maximum number of stack entries including TOS.
REQ-002 SHALL have parameter W, default 16, meaning the data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_op  in  2  command: 0 PUSH, 1 DROP, 2 BINOP, 3 UNOP.
REQ-008 SHALL have port cmd_aluop  in  4  ALU operation code for BINOP/UNOP.
REQ-009 SHALL have port cmd_data  in  W  PUSH operand.
REQ-010 SHALL have port alu_a  out  W  registered ALU operand A (NOS).
REQ-011 SHALL have port alu_b  out  W  registered ALU operand B (TOS).
REQ-012 SHALL have port alu_op  out  4  registered ALU opcode.
REQ-013 SHALL have port alu_res  in  W  combinational result from the external ALU.
REQ-014 SHALL have port tos  out  W  current top of stack.
REQ-015 SHALL have port depth  out  5  number of valid entries, 0..DEPTH.
REQ-016 SHALL have port done  out  1  one-cycle pulse when a command commits or is rejected.
REQ-017 SHALL have port err  out  3  sticky flags: [0] underflow, [1] overflow, [2] illegal op or divide by zero.
REQ-018 SHALL have port err_clr  in  1  clears err.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, EXEC; cmd_ready SHALL be 1 only in IDLE.
REQ-020 PUSH SHALL commit in the acceptance cycle: the old TOS moves to memory, tos = cmd_data, depth+1, done=1 on the next cycle.
REQ-021 DROP SHALL commit in the acceptance cycle: tos = the memory top (0 if depth becomes 0), depth-1.
REQ-022 BINOP SHALL go IDLE -> FETCH (latch NOS into alu_a, TOS into alu_b, cmd_aluop into alu_op) -> EXEC (tos = alu_res, depth-1, done=1) -> IDLE; 3 cycles from acceptance to done.
REQ-023 UNOP SHALL be legal only for aluop 9 or 10; it SHALL go IDLE -> EXEC with alu_b = TOS, then tos = alu_res with depth unchanged.
REQ-024 alu_a, alu_b and alu_op SHALL stay constant throughout EXEC; alu_res SHALL be sampled only at the end of EXEC.
REQ-025 PUSH at depth==DEPTH SHALL set err[1] with no state change and done=1.
REQ-026 DROP or UNOP at depth 0, or BINOP at depth <2, SHALL set err[0] with no state change and done=1.
REQ-027 aluop 0, UNOP with aluop other than 9/10, or aluop 4/5 with TOS==0 SHALL set err[2] with no state change and done=1.
REQ-028 Error checks SHALL be evaluated in IDLE at acceptance, so a rejected command returns done after 1 cycle and never enters FETCH/EXEC.
REQ-029 If err_clr coincides with a new error, the new error bit SHALL be set and other bits cleared.
REQ-030 Arithmetic SHALL be performed entirely by the external ALU; the block SHALL NOT modify or truncate alu_res.
REQ-031 cmd inputs SHALL be ignored outside IDLE.

Reset
REQ-032 rst SHALL force state=IDLE, depth=0, tos=0, alu_a/alu_b/alu_op=0, done=0, err=0, cmd_ready=1 on the next edge, including mid-BINOP.
REQ-033 Stack memory contents SHALL need no reset.

Structure
REQ-034 The cmd_op encodings, FSM state encodings and ALU opcode constants (1..15, including DIV=4, MOD=5, NOT=9, PASS=10) SHALL live in a shared package also used by the ALU and the decoder.
REQ-035 DEPTH-1 entries below TOS SHALL be held in a register array; TOS SHALL be a separate register.
REQ-036 A sub-module dstack_mem (register-array stack with push/pop/peek) SHALL be used; the ALU SHALL be instantiated outside this block.

Verification
REQ-037 PUSH 7, PUSH 3, BINOP aluop 2 -> tos=4, depth=1, done exactly 3 cycles after acceptance; alu_a=7, alu_b=3 during EXEC.
REQ-038 PUSH 5, UNOP aluop 9 -> tos=0xFFFA, depth=1; UNOP aluop 1 -> err[2]=1, tos unchanged.
REQ-039 17 PUSHes with DEPTH=16 -> 17th sets err[1], depth=16, tos = 16th value; 16 DROPs then DROP -> err[0], depth=0, tos=0.
REQ-040 PUSH 9, PUSH 0, BINOP aluop 4 -> err[2]=1, depth=2, tos=0, no FSM activity; err_clr -> err=0.
REQ-041 rst asserted in FETCH of a BINOP -> next cycle depth=0, tos=0, cmd_ready=1, done never pulses.
